// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package counter_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    longint unsigned x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler_tick.sv
// Enable prescaler: emits one TICK per DIV enabled cycles.
module prescaler_tick
  import counter_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic Clk,
  input  logic RSTB,
  input  logic EN,
  input  logic SCLR,
  output logic TICK
);

  localparam int unsigned PW = (clog2(DIV) > 1) ? clog2(DIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  // Tick on the last enabled cycle of each prescale period.
  assign TICK = EN && (pcnt == PLAST);

  // Prescale counter: holds while EN is low, cleared by reset or SCLR.
  always_ff @(posedge Clk) begin
    if (!RSTB) begin
      pcnt <= '0;
    end else if (SCLR) begin
      pcnt <= '0;
    end else if (EN) begin
      if (pcnt == PLAST) pcnt <= '0;
      else               pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with clear, clipped load, wrap or
// saturate at the bounds, enable prescaler, terminal count and carry pulse.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int unsigned SATURATE = MODE_WRAP,
  parameter int unsigned DIV      = 1
) (
  input  logic             Clk,
  input  logic             RSTB,
  input  logic             EN,
  input  logic             UP,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CO
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  logic             tick;
  logic             sclr;
  logic [WIDTH-1:0] q_nxt;
  logic             co_nxt;

  // Clear and load both restart the prescale period.
  assign sclr = CLR || LD;

  prescaler_tick #(
    .DIV (DIV)
  ) u_prescaler (
    .Clk  (Clk),
    .RSTB (RSTB),
    .EN   (EN),
    .SCLR (sclr),
    .TICK (tick)
  );

  // Terminal count follows the current direction combinationally.
  assign TC = UP ? (Q == MAXV) : (Q == '0);

  // Next count and carry: CLR > LD > step > hold.
  always_comb begin
    q_nxt  = Q;
    co_nxt = 1'b0;
    if (CLR) begin
      q_nxt = '0;
    end else if (LD) begin
      q_nxt = (D > MAXV) ? MAXV : D;
    end else if (tick) begin
      co_nxt = TC;
      if (TC) begin
        if (SATURATE != MODE_SAT) q_nxt = UP ? '0 : MAXV;
      end else begin
        q_nxt = UP ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
      end
    end
  end

  // Count and carry registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!RSTB) begin
      Q  <= '0;
      CO <= 1'b0;
    end else begin
      Q  <= q_nxt;
      CO <= co_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three instances (wrap/DIV1, saturate/DIV1,
// wrap/DIV3), all WIDTH=4, MAX_VAL=9.
module tb_counter_updown_mod;

  typedef struct {
    logic [3:0] q;
    logic       co;
    logic       tc;
    string      nm;
  } exp_t;

  typedef struct {
    logic       en;
    logic       up;
    logic       clr;
    logic       ld;
    logic [3:0] d;
    logic [3:0] q;
    logic       co;
    logic       tc;
    string      nm;
  } vec_t;

  logic       Clk;
  logic       rstb [3];
  logic       en   [3];
  logic       up   [3];
  logic       clr  [3];
  logic       ld   [3];
  logic [3:0] d    [3];
  logic [3:0] q    [3];
  logic       tc   [3];
  logic       co   [3];

  exp_t sbq[$];
  vec_t vecs[$];
  int   checks;
  int   errors;

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .DIV(1)) u_w (
    .Clk(Clk), .RSTB(rstb[0]), .EN(en[0]), .UP(up[0]), .CLR(clr[0]),
    .LD(ld[0]), .D(d[0]), .Q(q[0]), .TC(tc[0]), .CO(co[0]));

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .DIV(1)) u_s (
    .Clk(Clk), .RSTB(rstb[1]), .EN(en[1]), .UP(up[1]), .CLR(clr[1]),
    .LD(ld[1]), .D(d[1]), .Q(q[1]), .TC(tc[1]), .CO(co[1]));

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .DIV(3)) u_d (
    .Clk(Clk), .RSTB(rstb[2]), .EN(en[2]), .UP(up[2]), .CLR(clr[2]),
    .LD(ld[2]), .D(d[2]), .Q(q[2]), .TC(tc[2]), .CO(co[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic e, input logic u, input logic c,
                              input logic l, input logic [3:0] dv,
                              input logic [3:0] eq, input logic eco,
                              input logic etc, input string nm);
    vec_t v;
    v.en = e; v.up = u; v.clr = c; v.ld = l; v.d = dv;
    v.q = eq; v.co = eco; v.tc = etc; v.nm = nm;
    return v;
  endfunction

  // Pop the oldest expectation and compare it with instance s.
  task automatic check(input int s);
    exp_t ex;
    ex = sbq.pop_front();
    checks++;
    if (q[s] !== ex.q) begin
      errors++;
      $display("FAIL %s[%0d].Q got %0d expected %0d", ex.nm, s, q[s], ex.q);
    end
    checks++;
    if (co[s] !== ex.co) begin
      errors++;
      $display("FAIL %s[%0d].CO got %b expected %b", ex.nm, s, co[s], ex.co);
    end
    checks++;
    if (tc[s] !== ex.tc) begin
      errors++;
      $display("FAIL %s[%0d].TC got %b expected %b", ex.nm, s, tc[s], ex.tc);
    end
  endtask

  // One clock cycle on instance s; the other instances idle.
  task automatic cyc(input int s, input logic e, input logic u, input logic c,
                     input logic l, input logic [3:0] dv, input logic r,
                     input logic [3:0] eq, input logic eco, input logic etc,
                     input string nm);
    exp_t ex;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; clr[i] = 1'b0; ld[i] = 1'b0; rstb[i] = 1'b1;
    end
    en[s] = e; up[s] = u; clr[s] = c; ld[s] = l; d[s] = dv; rstb[s] = r;
    ex.q = eq; ex.co = eco; ex.tc = etc; ex.nm = nm;
    sbq.push_back(ex);
    @(posedge Clk);
    #1;
    check(s);
  endtask

  initial begin
    exp_t ex;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      rstb[i] = 1'b0; en[i] = 1'b1; up[i] = 1'b1;
      clr[i] = 1'b0; ld[i] = 1'b0; d[i] = 4'd0;
    end

    // Wrap instance vectors, starting from reset (Q=0).
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd1,0,0, "up1"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd2,0,0, "up2"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd3,0,0, "up3"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd4,0,0, "up4"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd5,0,0, "up5"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd6,0,0, "up6"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd7,0,0, "up7"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd8,0,0, "up8"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd9,0,1, "up9"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd0,1,0, "up_wrap"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd1,0,0, "up11"));
    vecs.push_back(mk(1,1,0,0,4'd0, 4'd2,0,0, "up12"));
    vecs.push_back(mk(1,1,1,0,4'd0, 4'd0,0,0, "clr"));
    vecs.push_back(mk(1,0,0,0,4'd0, 4'd9,1,0, "dn_wrap"));
    vecs.push_back(mk(1,0,0,0,4'd0, 4'd8,0,0, "dn8"));
    vecs.push_back(mk(1,0,0,0,4'd0, 4'd7,0,0, "dn7"));
    vecs.push_back(mk(0,0,0,0,4'd0, 4'd7,0,0, "hold"));
    vecs.push_back(mk(0,0,0,1,4'd15,4'd9,0,0, "ld_clip15"));
    vecs.push_back(mk(0,0,1,1,4'd5, 4'd0,0,1, "ld_clr"));
    vecs.push_back(mk(1,1,0,1,4'd5, 4'd5,0,0, "ld_tick"));
    vecs.push_back(mk(0,1,0,1,4'd10,4'd9,0,1, "ld_clip10"));
    vecs.push_back(mk(1,1,0,1,4'd3, 4'd3,0,0, "ld_tick_tc"));
    vecs.push_back(mk(1,0,0,0,4'd0, 4'd2,0,0, "dir_change"));
    vecs.push_back(mk(0,1,0,0,4'd0, 4'd2,0,0, "hold_up"));
    vecs.push_back(mk(0,0,0,1,4'd0, 4'd0,0,1, "ld0"));
    vecs.push_back(mk(1,0,0,0,4'd0, 4'd9,1,0, "dn_wrap2"));

    // Reset state on every instance, TC with both directions.
    repeat (2) @(posedge Clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      ex.q = 4'd0; ex.co = 1'b0; ex.tc = 1'b0; ex.nm = "rst_up";
      sbq.push_back(ex);
      check(s);
    end
    @(negedge Clk);
    for (int i = 0; i < 3; i++) up[i] = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      ex.q = 4'd0; ex.co = 1'b0; ex.tc = 1'b1; ex.nm = "rst_dn";
      sbq.push_back(ex);
      check(s);
    end

    // Table-driven run on the wrap instance.
    foreach (vecs[i])
      cyc(0, vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].ld, vecs[i].d, 1'b1,
          vecs[i].q, vecs[i].co, vecs[i].tc, vecs[i].nm);

    // Saturate: load 7 and count up into the upper bound.
    cyc(1, 0,1,0,1,4'd7, 1, 4'd7,0,0, "sat_ld7");
    cyc(1, 1,1,0,0,4'd0, 1, 4'd8,0,0, "sat8");
    cyc(1, 1,1,0,0,4'd0, 1, 4'd9,0,1, "sat9");
    cyc(1, 1,1,0,0,4'd0, 1, 4'd9,1,1, "sat_hold1");
    cyc(1, 1,1,0,0,4'd0, 1, 4'd9,1,1, "sat_hold2");
    cyc(1, 0,1,0,0,4'd0, 1, 4'd9,0,1, "sat_idle");
    cyc(1, 1,0,0,0,4'd0, 1, 4'd8,0,0, "sat_dn");
    cyc(1, 0,0,0,1,4'd0, 1, 4'd0,0,1, "sat_ld0");
    cyc(1, 1,0,0,0,4'd0, 1, 4'd0,1,1, "sat_floor");

    // DIV=3: spacing, EN gap holds prescaler, CLR restarts it.
    cyc(2, 1,1,0,0,4'd0, 1, 4'd0,0,0, "div_p1");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd0,0,0, "div_p2");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd1,0,0, "div_step1");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd1,0,0, "div_p1b");
    cyc(2, 0,1,0,0,4'd0, 1, 4'd1,0,0, "div_gap1");
    cyc(2, 0,1,0,0,4'd0, 1, 4'd1,0,0, "div_gap2");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd1,0,0, "div_p2b");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd2,0,0, "div_step2");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd2,0,0, "div_p1c");
    cyc(2, 1,1,1,0,4'd0, 1, 4'd0,0,0, "div_clr");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd0,0,0, "div_c1");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd0,0,0, "div_c2");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd1,0,0, "div_cstep");

    // DIV=3: reset mid-prescale at Q=5 discards the partial count.
    cyc(2, 0,1,0,1,4'd5, 1, 4'd5,0,0, "div_ld5");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd5,0,0, "div_r1");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd5,0,0, "div_r2");
    cyc(2, 1,1,0,0,4'd0, 0, 4'd0,0,0, "div_rst");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd0,0,0, "div_a1");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd0,0,0, "div_a2");
    cyc(2, 1,1,0,0,4'd0, 1, 4'd1,0,0, "div_astep");

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left %0d expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
